mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Sits between IFU/MEM stages and the memory/DPI bridge.
- One outstanding transaction at a time; LSU has priority, with a starvation guard for IFU.
- Handshaked valid/ready requests, registered single-cycle response pulses routed to the owner.

Parameters:
- WIDTH, 64, address and data width.
- STARVE_MAX, 3, consecutive IFU arbitration losses after which IFU wins the next tie.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- if_req_valid  in  1  IFU fetch request.
- if_req_ready  out  1  IFU request accepted this cycle.
- if_req_addr  in  WIDTH  fetch address.
- if_resp_valid  out  1  fetch data valid, 1-cycle pulse.
- if_resp_data  out  WIDTH  fetch data.
- ls_req_valid  in  1  LSU request.
- ls_req_ready  out  1  LSU request accepted.
- ls_req_addr  in  WIDTH  load/store address.
- ls_req_wen  in  1  1=store, 0=load.
- ls_req_wdata  in  WIDTH  store data.
- ls_req_wmask  in  WIDTH/8  store byte mask.
- ls_resp_valid  out  1  load data / store ack, 1-cycle pulse.
- ls_resp_data  out  WIDTH  load data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask  out  WIDTH/1/WIDTH/WIDTH/8  latched request fields.
- mem_resp_valid  in  1  memory response.
- mem_resp_data  in  WIDTH  memory read data.

Behaviour:
- FSM states:
  - IDLE: arbitrate.
  - REQ: drive memory request.
  - RESP: wait for the memory response.
- Reset (async, rst=1): state IDLE, starve counter 0, owner IFU, all latched request fields 0. All outputs 0: *_ready, *_resp_valid, *_resp_data, mem_req_*.
- Arbitration is combinational, and only in IDLE:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: LSU wins, unless starve_cnt==STARVE_MAX, in which case IFU wins.
  - Outside IDLE both readys are 0.
- Accept on valid&&ready: latch addr/wen/wdata/wmask and the owner, then go IDLE->REQ.
  - IFU requests latch wen=0 and wmask=0.
- Starve counter:
  - +1 when if_req_valid=1 and LSU is granted.
  - Cleared when IFU is granted.
  - Saturates at STARVE_MAX.
  - Unchanged otherwise.
- REQ: mem_req_valid=1 with the latched fields held stable until mem_req_ready=1, then go to RESP. Fields are held after the handshake and are not cleared.
- RESP: wait for mem_resp_valid=1. On that edge, register mem_resp_data into the owner's resp_data, pulse the owner's resp_valid for the next cycle only, and go to IDLE.
  - The non-owner's resp_valid stays 0.
  - resp_data holds its value until the next response to that requester.
- Stores still require mem_resp_valid; ls_resp_valid pulses as the ack, and ls_resp_data takes mem_resp_data unconditionally.
- mem_resp_valid is ignored in IDLE and REQ: no pulse, no state change. The memory must not respond in the same cycle it accepts a request.
- Minimum latency: accept at cycle 0, mem_req_valid at cycle 1, mem_req_ready at cycle 1, mem_resp_valid at cycle 2, owner resp_valid at cycle 3.
- The resp_valid pulse cycle is IDLE, so a new grant may occur in the same cycle (back-to-back allowed).
- Requester valid dropped before grant: no effect, nothing latched.
- Reset mid-transaction: the transaction is abandoned, no response pulse, and any later mem_resp_valid is ignored while in IDLE.

Decomposition:
- Shared package:
  - state encoding (IDLE/REQ/RESP, 2 bits);
  - owner encoding (OWN_IF=0, OWN_LS=1);
  - mask width function WIDTH/8.
- Sub-module arb_prio: the starvation counter plus the grant-decision logic. Inputs if_valid, ls_valid, idle, accept; outputs grant_if, grant_ls. The top keeps the FSM, latches and response routing.

Test Plan:
- IFU-only fetch: if_req_valid, addr 0x80000000, memory ready immediately and returns 0x00000013 one cycle later -> if_req_ready at cycle 0, mem_req_addr=0x80000000 at cycle 1, if_resp_valid=1 with data 0x13 at cycle 3. ls_resp_valid stays 0.
- Simultaneous requests, counter 0: both valid -> ls_req_ready=1, if_req_ready=0, starve_cnt=1. After the LSU response, the IFU is granted if it is still valid and the LSU is idle.
- Starvation: LSU valid continuously, IFU valid continuously -> LSU granted 3 times, the 4th grant goes to IFU, and the counter returns to 0.
- Store ack: ls_req_wen=1, wdata 0xDEADBEEF, wmask 0x0F -> mem_req_wen=1 and wmask=0x0F held while mem_req_ready is stalled 5 cycles; ls_resp_valid pulses once after mem_resp_valid.
- Spurious response: mem_resp_valid asserted in IDLE and in REQ -> no resp pulse, state unchanged.
- Async reset in RESP: assert rst between clock edges -> all outputs 0 immediately, state IDLE. A later mem_resp_valid produces no pulse, and the next request is handled normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the IFU/LSU memory arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    function automatic int mask_w(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/mem_arbiter_arb_prio.sv
// rtl/mem_arbiter_arb_prio.sv - LSU-first grant decision with an IFU starvation guard
module mem_arbiter_arb_prio #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid,
    input  logic ls_valid,
    input  logic idle,
    input  logic accept,
    output logic grant_if,
    output logic grant_ls
);

    localparam int            CW      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_q, starve_d;

    // IFU only beats a competing LSU once it has lost STARVE_MAX ties in a row.
    assign grant_if = idle && if_valid && (!ls_valid || (starve_q == CNT_MAX));
    assign grant_ls = idle && ls_valid && !grant_if;

    always_comb begin
        starve_d = starve_q;
        if (accept) begin
            if (grant_if) begin
                starve_d = '0;
            end else if (if_valid && (starve_q != CNT_MAX)) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding arbiter sharing one memory port between IFU and LSU
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int STARVE_MAX = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_req_valid,
    output logic                       if_req_ready,
    input  logic [WIDTH-1:0]           if_req_addr,
    output logic                       if_resp_valid,
    output logic [WIDTH-1:0]           if_resp_data,
    input  logic                       ls_req_valid,
    output logic                       ls_req_ready,
    input  logic [WIDTH-1:0]           ls_req_addr,
    input  logic                       ls_req_wen,
    input  logic [WIDTH-1:0]           ls_req_wdata,
    input  logic [mask_w(WIDTH)-1:0]   ls_req_wmask,
    output logic                       ls_resp_valid,
    output logic [WIDTH-1:0]           ls_resp_data,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [WIDTH-1:0]           mem_req_addr,
    output logic                       mem_req_wen,
    output logic [WIDTH-1:0]           mem_req_wdata,
    output logic [mask_w(WIDTH)-1:0]   mem_req_wmask,
    input  logic                       mem_resp_valid,
    input  logic [WIDTH-1:0]           mem_resp_data
);

    localparam int MW = mask_w(WIDTH);

    state_t           state_q, state_d;
    owner_t           owner_q;
    logic [WIDTH-1:0] addr_q, wdata_q, if_data_q, ls_data_q;
    logic [MW-1:0]    wmask_q;
    logic             wen_q, if_pulse_q, ls_pulse_q;
    logic             idle, accept, grant_if, grant_ls;

    // Gating with rst keeps both readys low while reset is held.
    assign idle   = (state_q == ST_IDLE) && !rst;
    assign accept = (if_req_valid && grant_if) || (ls_req_valid && grant_ls);

    mem_arbiter_arb_prio #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb_prio (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_req_valid),
        .ls_valid (ls_req_valid),
        .idle     (idle),
        .accept   (accept),
        .grant_if (grant_if),
        .grant_ls (grant_ls)
    );

    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_REQ;
            ST_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = ST_RESP;
            end
            ST_RESP: if (mem_resp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= OWN_IF;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            if_pulse_q <= 1'b0;
            ls_pulse_q <= 1'b0;
            if_data_q  <= '0;
            ls_data_q  <= '0;
        end else begin
            if_pulse_q <= 1'b0;
            ls_pulse_q <= 1'b0;
            if (accept) begin
                owner_q <= grant_ls ? OWN_LS : OWN_IF;
                addr_q  <= grant_ls ? ls_req_addr : if_req_addr;
                wen_q   <= grant_ls && ls_req_wen;
                wdata_q <= grant_ls ? ls_req_wdata : '0;
                wmask_q <= grant_ls ? ls_req_wmask : '0;
            end
            // Store acks also carry mem_resp_data; the LSU ignores it for stores.
            if ((state_q == ST_RESP) && mem_resp_valid) begin
                if (owner_q == OWN_LS) begin
                    ls_pulse_q <= 1'b1;
                    ls_data_q  <= mem_resp_data;
                end else begin
                    if_pulse_q <= 1'b1;
                    if_data_q  <= mem_resp_data;
                end
            end
        end
    end

    assign if_req_ready  = grant_if;
    assign ls_req_ready  = grant_ls;
    assign if_resp_valid = if_pulse_q;
    assign if_resp_data  = if_data_q;
    assign ls_resp_valid = ls_pulse_q;
    assign ls_resp_data  = ls_data_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter
module tb_mem_arbiter;

    localparam int WIDTH      = 64;
    localparam int MW         = WIDTH / 8;
    localparam int STARVE_MAX = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_req_valid, if_req_ready, if_resp_valid;
    logic [WIDTH-1:0] if_req_addr, if_resp_data;
    logic             ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid;
    logic [WIDTH-1:0] ls_req_addr, ls_req_wdata, ls_resp_data;
    logic [MW-1:0]    ls_req_wmask;
    logic             mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [WIDTH-1:0] mem_req_addr, mem_req_wdata, mem_resp_data;
    logic [MW-1:0]    mem_req_wmask;

    int               n_checks = 0;
    int               n_pass   = 0;
    int               m_starve = 0;
    logic [WIDTH-1:0] m_if_data = '0;
    logic [WIDTH-1:0] m_ls_data = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(WIDTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
        .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    // Reference arbitration: 0 = nobody, 1 = IFU, 2 = LSU.
    function automatic int predict(input bit ifv, input bit lsv);
        if (ifv && (!lsv || m_starve == STARVE_MAX)) return 1;
        if (lsv) return 2;
        return 0;
    endfunction

    task automatic model_accept(input int w, input bit ifv);
        if (w == 1) m_starve = 0;
        else if (w == 2 && ifv && m_starve < STARVE_MAX) m_starve = m_starve + 1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Plays the memory for one transaction from the first REQ cycle up to the response-pulse cycle.
    task automatic serve_mem(input int stall, input int rdelay, input logic [WIDTH-1:0] rdata, input bit noise,
                             output logic [WIDTH-1:0] f_addr, output logic f_wen,
                             output logic [WIDTH-1:0] f_wdata, output logic [MW-1:0] f_wmask,
                             output int n_unstable, output int n_bad,
                             output logic p_if, output logic p_ls,
                             output logic [WIDTH-1:0] d_if, output logic [WIDTH-1:0] d_ls);
        n_unstable = 0;
        n_bad      = 0;
        f_addr = mem_req_addr; f_wen = mem_req_wen; f_wdata = mem_req_wdata; f_wmask = mem_req_wmask;
        for (int i = 0; i <= stall + rdelay + 1; i++) begin
            mem_req_ready  = (i == stall);
            mem_resp_valid = (i == stall + rdelay + 1) || (noise && i < stall && 1'($urandom_range(0, 1)));
            mem_resp_data  = (i == stall + rdelay + 1) ? rdata : {$urandom, $urandom};
            if (noise) begin
                if_req_valid = 1'($urandom_range(0, 1));
                ls_req_valid = 1'($urandom_range(0, 1));
            end
            #1;
            if (mem_req_valid !== (i <= stall) || if_req_ready !== 1'b0 || ls_req_ready !== 1'b0 ||
                if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) n_bad++;
            if ({mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== {f_addr, f_wen, f_wdata, f_wmask})
                n_unstable++;
            step;
        end
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        if (noise) begin
            if_req_valid = 1'b0;
            ls_req_valid = 1'b0;
        end
        p_if = if_resp_valid; p_ls = ls_resp_valid; d_if = if_resp_data; d_ls = ls_resp_data;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        if_req_valid = 1'b1; ls_req_valid = 1'b1; mem_resp_valid = 1'b1; mem_req_ready = 1'b1;
        if_req_addr = 64'h1234; ls_req_addr = 64'h5678; ls_req_wen = 1'b1;
        ls_req_wdata = 64'hFFFF; ls_req_wmask = 8'hFF; mem_resp_data = 64'hABCD;
        step;
        n_checks++; if (if_req_ready !== 1'b0) $display("FAIL reset_if_ready: got %0b want 0", if_req_ready); else n_pass++;
        n_checks++; if (ls_req_ready !== 1'b0) $display("FAIL reset_ls_ready: got %0b want 0", ls_req_ready); else n_pass++;
        n_checks++; if ({if_resp_valid, ls_resp_valid} !== 2'b00) $display("FAIL reset_resp_valid: got %b want 00", {if_resp_valid, ls_resp_valid}); else n_pass++;
        n_checks++; if ({if_resp_data, ls_resp_data} !== '0) $display("FAIL reset_resp_data: got %h/%h want 0", if_resp_data, ls_resp_data); else n_pass++;
        n_checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== '0)
            $display("FAIL reset_mem_req: got v=%0b a=%h w=%0b d=%h m=%h want all 0", mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask); else n_pass++;
        if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0; ls_req_wen = 1'b0;
        rst = 1'b0;
        step;
    endtask

    task automatic test_ifu_fetch;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0000; mem_req_ready = 1'b1;
        #1;
        n_checks++; if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) $display("FAIL fetch_c0_ready: got if=%0b ls=%0b want 1/0", if_req_ready, ls_req_ready); else n_pass++;
        model_accept(predict(1'b1, 1'b0), 1'b1);
        step;
        if_req_valid = 1'b0;
        #1;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) $display("FAIL fetch_c1_req: got v=%0b a=%h want 1/80000000", mem_req_valid, mem_req_addr); else n_pass++;
        n_checks++; if (mem_req_wen !== 1'b0 || mem_req_wmask !== 8'h00) $display("FAIL fetch_c1_wen: got wen=%0b mask=%h want 0/00", mem_req_wen, mem_req_wmask); else n_pass++;
        step;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h13;
        #1;
        n_checks++; if (mem_req_valid !== 1'b0 || if_resp_valid !== 1'b0) $display("FAIL fetch_c2: got req=%0b resp=%0b want 0/0", mem_req_valid, if_resp_valid); else n_pass++;
        step;
        mem_resp_valid = 1'b0;
        n_checks++; if (if_resp_valid !== 1'b1 || if_resp_data !== 64'h13) $display("FAIL fetch_c3_resp: got v=%0b d=%h want 1/13", if_resp_valid, if_resp_data); else n_pass++;
        n_checks++; if (ls_resp_valid !== 1'b0) $display("FAIL fetch_c3_ls_quiet: got %0b want 0", ls_resp_valid); else n_pass++;
        m_if_data = 64'h13;
        step;
        n_checks++; if (if_resp_valid !== 1'b0 || if_resp_data !== m_if_data) $display("FAIL fetch_c4_hold: got v=%0b d=%h want 0/%h", if_resp_valid, if_resp_data, m_if_data); else n_pass++;
    endtask

    task automatic test_simultaneous;
        logic [WIDTH-1:0] fa, fd, di, dl, rd;
        logic fw, pi, pl;
        logic [MW-1:0] fm;
        int nu, nb;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
        ls_req_valid = 1'b1; ls_req_addr = 64'h9000_0000; ls_req_wen = 1'b0;
        #1;
        n_checks++; if (ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) $display("FAIL simul_grant: got if=%0b ls=%0b want 0/1", if_req_ready, ls_req_ready); else n_pass++;
        model_accept(2, 1'b1);
        step;
        ls_req_valid = 1'b0;
        rd = {$urandom, $urandom};
        serve_mem(1, 0, rd, 1'b0, fa, fw, fd, fm, nu, nb, pi, pl, di, dl);
        n_checks++; if (fa !== 64'h9000_0000 || nb !== 0) $display("FAIL simul_ls_req: got a=%h bad=%0d want 90000000/0", fa, nb); else n_pass++;
        n_checks++; if (pl !== 1'b1 || pi !== 1'b0 || dl !== rd) $display("FAIL simul_ls_resp: got ls=%0b if=%0b d=%h want 1/0/%h", pl, pi, dl, rd); else n_pass++;
        m_ls_data = rd;
        #1;
        n_checks++; if (if_req_ready !== 1'b1) $display("FAIL simul_b2b_if_ready: got %0b want 1", if_req_ready); else n_pass++;
        model_accept(1, 1'b1);
        step;
        if_req_valid = 1'b0;
        n_checks++; if (ls_resp_valid !== 1'b0) $display("FAIL simul_ls_single_pulse: got %0b want 0", ls_resp_valid); else n_pass++;
        rd = {$urandom, $urandom};
        serve_mem(0, 2, rd, 1'b0, fa, fw, fd, fm, nu, nb, pi, pl, di, dl);
        n_checks++; if (fa !== 64'h8000_0004 || pi !== 1'b1 || pl !== 1'b0 || di !== rd)
            $display("FAIL simul_if_txn: got a=%h if=%0b ls=%0b d=%h want 80000004/1/0/%h", fa, pi, pl, di, rd); else n_pass++;
        m_if_data = rd;
        step;
    endtask

    task automatic test_starvation;
        logic [WIDTH-1:0] fa, fd, di, dl, rd;
        logic fw, pi, pl;
        logic [MW-1:0] fm;
        int nu, nb, w;
        string seq = "";
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0100;
        ls_req_valid = 1'b1; ls_req_addr = 64'h9000_0100; ls_req_wen = 1'b0;
        for (int g = 0; g < 5; g++) begin
            #1;
            w = predict(1'b1, 1'b1);
            seq = {seq, (if_req_ready === 1'b1) ? "I" : (ls_req_ready === 1'b1) ? "L" : "-"};
            model_accept(w, 1'b1);
            step;
            rd = {$urandom, $urandom};
            serve_mem($urandom_range(0, 2), $urandom_range(0, 2), rd, 1'b0, fa, fw, fd, fm, nu, nb, pi, pl, di, dl);
            n_checks++; if (pi !== (w == 1) || pl !== (w == 2)) $display("FAIL starve_owner_%0d: got if=%0b ls=%0b want owner %0d", g, pi, pl, w); else n_pass++;
            if (w == 1) m_if_data = rd; else m_ls_data = rd;
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        n_checks++; if (seq != "LLLIL") $display("FAIL starve_sequence: got %s want LLLIL", seq); else n_pass++;
        step;
    endtask

    task automatic test_store;
        logic [WIDTH-1:0] fa, fd, di, dl, rd;
        logic fw, pi, pl;
        logic [MW-1:0] fm;
        int nu, nb;
        ls_req_valid = 1'b1; ls_req_addr = 64'h9000_0200; ls_req_wen = 1'b1;
        ls_req_wdata = 64'hDEAD_BEEF; ls_req_wmask = 8'h0F;
        #1;
        n_checks++; if (ls_req_ready !== 1'b1) $display("FAIL store_ready: got %0b want 1", ls_req_ready); else n_pass++;
        model_accept(2, 1'b0);
        step;
        ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
        rd = {$urandom, $urandom};
        serve_mem(5, 1, rd, 1'b0, fa, fw, fd, fm, nu, nb, pi, pl, di, dl);
        n_checks++; if (fw !== 1'b1 || fm !== 8'h0F || fd !== 64'hDEAD_BEEF || fa !== 64'h9000_0200)
            $display("FAIL store_fields: got wen=%0b m=%h d=%h a=%h want 1/0f/deadbeef/90000200", fw, fm, fd, fa); else n_pass++;
        n_checks++; if (nu !== 0 || nb !== 0) $display("FAIL store_stall_stable: got unstable=%0d bad=%0d want 0/0", nu, nb); else n_pass++;
        n_checks++; if (pl !== 1'b1 || pi !== 1'b0 || dl !== rd) $display("FAIL store_ack: got ls=%0b if=%0b d=%h want 1/0/%h", pl, pi, dl, rd); else n_pass++;
        m_ls_data = rd;
        step;
        n_checks++; if (ls_resp_valid !== 1'b0) $display("FAIL store_ack_once: got %0b want 0", ls_resp_valid); else n_pass++;
    endtask

    task automatic test_spurious;
        logic [WIDTH-1:0] fa, fd, di, dl, rd;
        logic fw, pi, pl;
        logic [MW-1:0] fm;
        int nu, nb, seen = 0;
        for (int i = 0; i < 3; i++) begin
            mem_resp_valid = 1'b1; mem_resp_data = {$urandom, $urandom};
            step;
            if (if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
                if_resp_data !== m_if_data || ls_resp_data !== m_ls_data) seen++;
        end
        mem_resp_valid = 1'b0;
        n_checks++; if (seen !== 0) $display("FAIL spurious_idle: got %0d disturbed cycles want 0", seen); else n_pass++;
        if_req_valid = 1'b1; if_req_addr = 64'h8000_0300;
        #1;
        n_checks++; if (if_req_ready !== 1'b1) $display("FAIL spurious_still_idle: got ready %0b want 1", if_req_ready); else n_pass++;
        model_accept(1, 1'b1);
        step;
        if_req_valid = 1'b0;
        rd = {$urandom, $urandom};
        serve_mem(3, 1, rd, 1'b1, fa, fw, fd, fm, nu, nb, pi, pl, di, dl);
        n_checks++; if (nb !== 0 || pi !== 1'b1 || pl !== 1'b0 || di !== rd)
            $display("FAIL spurious_req: got bad=%0d if=%0b ls=%0b d=%h want 0/1/0/%h", nb, pi, pl, di, rd); else n_pass++;
        m_if_data = rd;
        step;
    endtask

    task automatic test_reset_in_resp;
        logic [WIDTH-1:0] fa, fd, di, dl, rd;
        logic fw, pi, pl;
        logic [MW-1:0] fm;
        int nu, nb;
        ls_req_valid = 1'b1; ls_req_addr = 64'h9000_0400; ls_req_wen = 1'b0;
        #1;
        model_accept(2, 1'b0);
        step;
        ls_req_valid = 1'b0; mem_req_ready = 1'b1;
        step;
        mem_req_ready = 1'b0; if_req_valid = 1'b1; if_req_addr = 64'h8000_0400;
        #3;
        rst = 1'b1;
        #1;
        m_starve = 0; m_if_data = '0; m_ls_data = '0;
        n_checks++; if ({mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask} !== '0)
            $display("FAIL rst_resp_mem_req: got v=%0b a=%h want all 0", mem_req_valid, mem_req_addr); else n_pass++;
        n_checks++; if ({if_req_ready, ls_req_ready, if_resp_valid, ls_resp_valid} !== 4'b0 || {if_resp_data, ls_resp_data} !== '0)
            $display("FAIL rst_resp_outputs: got rdy=%b%b d=%h/%h want 0", if_req_ready, ls_req_ready, if_resp_data, ls_resp_data); else n_pass++;
        step;
        rst = 1'b0; if_req_valid = 1'b0;
        mem_resp_valid = 1'b1; mem_resp_data = {$urandom, $urandom};
        step;
        mem_resp_valid = 1'b0;
        n_checks++; if ({if_resp_valid, ls_resp_valid, mem_req_valid} !== 3'b0 || ls_resp_data !== m_ls_data)
            $display("FAIL rst_late_resp: got if=%0b ls=%0b req=%0b d=%h want 0/0/0/%h", if_resp_valid, ls_resp_valid, mem_req_valid, ls_resp_data, m_ls_data); else n_pass++;
        if_req_valid = 1'b1;
        #1;
        model_accept(1, 1'b1);
        step;
        if_req_valid = 1'b0;
        rd = {$urandom, $urandom};
        serve_mem(0, 0, rd, 1'b0, fa, fw, fd, fm, nu, nb, pi, pl, di, dl);
        n_checks++; if (fa !== 64'h8000_0400 || pi !== 1'b1 || di !== rd) $display("FAIL rst_recover: got a=%h if=%0b d=%h want 80000400/1/%h", fa, pi, di, rd); else n_pass++;
        m_if_data = rd;
        step;
    endtask

    task automatic test_random;
        logic [WIDTH-1:0] fa, fd, di, dl, rd, ia, la, ld;
        logic fw, pi, pl, ifv, lsv, lw;
        logic [MW-1:0] fm, lm;
        int nu, nb, w;
        for (int it = 0; it < 60; it++) begin
            ifv = ($urandom_range(0, 3) != 0); lsv = ($urandom_range(0, 3) != 0);
            ia = {$urandom, $urandom}; la = {$urandom, $urandom}; ld = {$urandom, $urandom};
            lw = 1'($urandom_range(0, 1)); lm = 8'($urandom);
            if_req_valid = ifv; if_req_addr = ia;
            ls_req_valid = lsv; ls_req_addr = la; ls_req_wen = lw; ls_req_wdata = ld; ls_req_wmask = lm;
            mem_resp_valid = 1'($urandom_range(0, 1)); mem_resp_data = {$urandom, $urandom};
            #1;
            w = predict(ifv, lsv);
            n_checks++; if (if_req_ready !== (w == 1) || ls_req_ready !== (w == 2))
                $display("FAIL rnd_grant_%0d: got if=%0b ls=%0b want winner %0d", it, if_req_ready, ls_req_ready, w); else n_pass++;
            model_accept(w, ifv);
            step;
            if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_resp_valid = 1'b0;
            if (w == 0) begin
                #1;
                n_checks++; if (mem_req_valid !== 1'b0) $display("FAIL rnd_nogrant_%0d: got mem_req_valid %0b want 0", it, mem_req_valid); else n_pass++;
                continue;
            end
            rd = {$urandom, $urandom};
            serve_mem($urandom_range(0, 3), $urandom_range(0, 3), rd, 1'b1, fa, fw, fd, fm, nu, nb, pi, pl, di, dl);
            if (w == 1) begin
                n_checks++; if (fa !== ia || fw !== 1'b0 || fm !== '0) $display("FAIL rnd_if_fields_%0d: got a=%h w=%0b m=%h want %h/0/00", it, fa, fw, fm, ia); else n_pass++;
                m_if_data = rd;
            end else begin
                n_checks++; if (fa !== la || fw !== lw || fm !== lm || fd !== ld)
                    $display("FAIL rnd_ls_fields_%0d: got a=%h w=%0b m=%h d=%h want %h/%0b/%h/%h", it, fa, fw, fm, fd, la, lw, lm, ld); else n_pass++;
                m_ls_data = rd;
            end
            n_checks++; if (nu !== 0 || nb !== 0) $display("FAIL rnd_busy_%0d: got unstable=%0d bad=%0d want 0/0", it, nu, nb); else n_pass++;
            n_checks++; if (pi !== (w == 1) || pl !== (w == 2) || di !== m_if_data || dl !== m_ls_data)
                $display("FAIL rnd_resp_%0d: got if=%0b ls=%0b d=%h/%h want owner %0d d=%h/%h", it, pi, pl, di, dl, w, m_if_data, m_ls_data); else n_pass++;
            step;
            n_checks++; if (if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0 || if_resp_data !== m_if_data || ls_resp_data !== m_ls_data)
                $display("FAIL rnd_hold_%0d: got v=%0b%0b d=%h/%h want 00 %h/%h", it, if_resp_valid, ls_resp_valid, if_resp_data, ls_resp_data, m_if_data, m_ls_data); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        if_req_valid = 1'b0; if_req_addr = '0;
        ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        test_reset;
        test_ifu_fetch;
        test_simultaneous;
        test_starvation;
        test_store;
        test_spurious;
        test_reset_in_resp;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
